// File: rtl/spi_slave_io_pkg.sv
// Shared types and helpers for the SPI slave IO engine.
package spi_slave_io_pkg;

  typedef enum logic [1:0] {
    SPI_SLV_IDLE  = 2'b00,
    SPI_SLV_SHIFT = 2'b01,
    SPI_SLV_END   = 2'b10
  } spi_slv_state_e;

  // Bit of a byte that goes out on the cnt-th launch, for either bit order.
  function automatic logic tx_bit(input logic [7:0] data, input logic [2:0] cnt,
                                  input logic lsbfirst);
    tx_bit = lsbfirst ? data[cnt] : data[3'd7 - cnt];
  endfunction

endpackage

// File: rtl/oh_dsync.sv
// Multi-flop synchronizer for a single asynchronous pad signal.
module oh_dsync #(
  parameter int   SYNCS  = 2,
  parameter logic RSTVAL = 1'b0
) (
  input  logic clk,
  input  logic nreset,
  input  logic din,
  output logic dout
);

  logic [SYNCS-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nreset) sync_q <= {SYNCS{RSTVAL}};
    else         sync_q <= {sync_q[SYNCS-2:0], din};
  end

  assign dout = sync_q[SYNCS-1];

endmodule

// File: rtl/spi_slave_io.sv
// SPI slave IO engine: oversamples the pads in the clk domain, deserializes mosi
// and serializes a core-supplied byte stream onto miso.
module spi_slave_io
  import spi_slave_io_pkg::*;
#(
  parameter int SYNCS = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       en,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       lsbfirst,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       frame_done,
  output logic [1:0] spi_state
);

  // Handshake: at each byte load the byte is taken from tx_data when tx_valid=1,
  // signalled by a same-cycle tx_ready pulse; with tx_valid=0 the load still
  // happens (8'h00) and tx_underrun pulses instead. rx_valid is a one-cycle
  // pulse with no back-pressure.

  logic           sclk_s, ss_s, mosi_s, sclk_d;
  spi_slv_state_e state_q, state_d;
  logic [7:0]     rx_sh, tx_sh, rx_next, load_byte;
  logic [2:0]     rx_cnt, tx_cnt;
  logic           edge_det, lead, trail, sample, launch;
  logic           in_shift, sample_ok, launch_ok, abort, start, byte_done, load;

  oh_dsync #(.SYNCS(SYNCS), .RSTVAL(1'b0)) u_sync_sclk (
    .clk(clk), .nreset(nreset), .din(sclk), .dout(sclk_s)
  );
  // ss resets deasserted so no frame starts before the pad level has propagated.
  oh_dsync #(.SYNCS(SYNCS), .RSTVAL(1'b1)) u_sync_ss (
    .clk(clk), .nreset(nreset), .din(ss), .dout(ss_s)
  );
  oh_dsync #(.SYNCS(SYNCS), .RSTVAL(1'b0)) u_sync_mosi (
    .clk(clk), .nreset(nreset), .din(mosi), .dout(mosi_s)
  );

  always_ff @(posedge clk) begin
    if (!nreset) sclk_d <= 1'b0;
    else         sclk_d <= sclk_s;
  end

  assign edge_det  = sclk_s ^ sclk_d;
  assign lead      = edge_det & (sclk_s != cpol);
  assign trail     = edge_det & (sclk_s == cpol);
  assign sample    = cpha ? trail : lead;
  assign launch    = cpha ? lead : trail;

  // A rising ss overrides any edge seen in the same cycle.
  assign in_shift  = (state_q == SPI_SLV_SHIFT);
  assign abort     = in_shift & ss_s;
  assign sample_ok = in_shift & ~ss_s & sample;
  assign launch_ok = in_shift & ~ss_s & launch;
  assign start     = (state_q == SPI_SLV_IDLE) & ~ss_s & en;
  assign byte_done = sample_ok & (rx_cnt == 3'd7);
  assign load      = start | byte_done;
  assign load_byte = tx_valid ? tx_data : 8'h00;
  assign rx_next   = lsbfirst ? {mosi_s, rx_sh[7:1]} : {rx_sh[6:0], mosi_s};

  always_ff @(posedge clk) begin
    if (!nreset) state_q <= SPI_SLV_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPI_SLV_IDLE:  if (!ss_s && en) state_d = SPI_SLV_SHIFT;
      SPI_SLV_SHIFT: if (ss_s) state_d = SPI_SLV_END;
      SPI_SLV_END:   state_d = SPI_SLV_IDLE;
      default:       state_d = SPI_SLV_IDLE;
    endcase
  end

  always_comb begin
    miso_en     = 1'b0;
    frame_done  = 1'b0;
    tx_ready    = load & tx_valid;
    tx_underrun = load & ~tx_valid;
    spi_state   = state_q;
    case (state_q)
      SPI_SLV_SHIFT: miso_en = 1'b1;
      SPI_SLV_END:   frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      rx_sh    <= 8'h00;
      rx_cnt   <= 3'd0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        rx_sh  <= 8'h00;
        rx_cnt <= 3'd0;
      end else if (sample_ok) begin
        rx_sh  <= rx_next;
        rx_cnt <= rx_cnt + 3'd1;
        if (rx_cnt == 3'd7) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // With cpha=0 the first bit must be on miso before the first leading edge,
  // so the entry load doubles as launch 0.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      tx_sh  <= 8'h00;
      tx_cnt <= 3'd0;
      miso   <= 1'b0;
    end else if (abort) begin
      tx_cnt <= 3'd0;
    end else if (start) begin
      tx_sh <= load_byte;
      if (!cpha) begin
        miso   <= tx_bit(load_byte, 3'd0, lsbfirst);
        tx_cnt <= 3'd1;
      end else begin
        tx_cnt <= 3'd0;
      end
    end else if (state_q == SPI_SLV_IDLE) begin
      miso <= 1'b0;
    end else begin
      if (byte_done) tx_sh <= load_byte;
      if (launch_ok) begin
        miso   <= tx_bit(tx_sh, tx_cnt, lsbfirst);
        tx_cnt <= tx_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_io.sv
// Directed bench for spi_slave_io: an SPI master model on the pads and a
// tx byte source/rx collector on the core side.
`timescale 1ns/1ps
module tb_spi_slave_io;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       en = 1'b0, cpol = 1'b0, cpha = 1'b0, lsbfirst = 1'b0;
  logic       sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, miso_en, rx_valid, tx_ready, tx_underrun, frame_done;
  logic [7:0] rx_data;
  logic [1:0] spi_state;

  int checks = 0, errors = 0;

  logic [7:0] mst_tx_q[$], mst_rx_q[$], slv_tx_q[$], rx_got_q[$];
  int         tx_ready_cnt, underrun_cnt, frame_done_cnt, bad_trans, first_ur_rx;
  logic       pop_pending = 1'b0;
  logic [1:0] prev_state = 2'b00;

  spi_slave_io #(.SYNCS(2)) dut (
    .clk(clk), .nreset(nreset), .en(en), .cpol(cpol), .cpha(cpha),
    .lsbfirst(lsbfirst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .miso_en(miso_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .frame_done(frame_done), .spi_state(spi_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  // Core-side model: byte source popped on tx_ready, rx collector, pulse counters.
  always @(negedge clk) begin
    if (!nreset) begin
      pop_pending = 1'b0;
      prev_state  = 2'b00;
    end else begin
      if (pop_pending && slv_tx_q.size() > 0) void'(slv_tx_q.pop_front());
      pop_pending = 1'b0;
      if (rx_valid) rx_got_q.push_back(rx_data);
      if (tx_ready) begin
        tx_ready_cnt++;
        pop_pending = 1'b1;
      end
      if (tx_underrun) begin
        if (underrun_cnt == 0) first_ur_rx = rx_got_q.size();
        underrun_cnt++;
      end
      if (frame_done) frame_done_cnt++;
      if (prev_state == 2'b10 && spi_state != 2'b00) bad_trans++;
      prev_state = spi_state;
    end
    tx_valid = (slv_tx_q.size() != 0);
    tx_data  = tx_valid ? slv_tx_q[0] : 8'h00;
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_got_q.delete();
    tx_ready_cnt   = 0;
    underrun_cnt   = 0;
    frame_done_cnt = 0;
    bad_trans      = 0;
    first_ur_rx    = -1;
  endtask

  task automatic set_mode(input logic p, input logic h, input logic l);
    cpol     = p;
    cpha     = h;
    lsbfirst = l;
    sclk     = p;
    wait_clk(6);
  endtask

  // Master: sends mst_tx_q[0..nbytes-1], collects complete bytes in mst_rx_q;
  // abort_bits>0 raises ss after that many sclk cycles.
  task automatic spi_frame(input int nbytes, input int abort_bits);
    logic [7:0] b, r;
    logic       bitv;
    int         idx, nb;
    logic       aborted;
    nb = 0;
    aborted = 1'b0;
    mst_rx_q.delete();
    ss = 1'b0;
    wait_clk(2 * HALF);
    for (int k = 0; k < nbytes; k++) begin
      b = mst_tx_q[k];
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (abort_bits > 0 && nb == abort_bits) begin
          aborted = 1'b1;
          break;
        end
        idx  = lsbfirst ? i : 7 - i;
        bitv = b[idx];
        if (!cpha) begin
          mosi = bitv;
          wait_clk(HALF);
          r[idx] = miso;
          sclk = ~cpol;
          wait_clk(HALF);
          sclk = cpol;
        end else begin
          sclk = ~cpol;
          mosi = bitv;
          wait_clk(HALF);
          r[idx] = miso;
          sclk = cpol;
          wait_clk(HALF);
        end
        nb++;
      end
      if (aborted) break;
      mst_rx_q.push_back(r);
    end
    wait_clk(HALF);
    ss = 1'b1;
    wait_clk(2 * HALF + 4);
    mosi = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    nreset = 1'b0;
    wait_clk(3);
    checks++;
    if (spi_state !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got %0d exp 0", spi_state);
    end
    checks++;
    if ({miso, miso_en, rx_valid, tx_ready, tx_underrun, frame_done, rx_data} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 0",
               {miso, miso_en, rx_valid, tx_ready, tx_underrun, frame_done, rx_data});
    end
    nreset = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_byte();
    logic [7:0] got;
    set_mode(1'b0, 1'b0, 1'b0);
    clear_mon();
    slv_tx_q = '{8'h3C};
    mst_tx_q = '{8'hA5};
    spi_frame(1, 0);
    checks++;
    if (rx_got_q.size() !== 1) begin
      errors++;
      $display("FAIL byte_rx_count: got %0d exp 1", rx_got_q.size());
    end
    got = (rx_got_q.size() > 0) ? rx_got_q[0] : 8'hxx;
    checks++;
    if (got !== 8'hA5) begin
      errors++;
      $display("FAIL byte_rx_data: got %h exp a5", got);
    end
    got = (mst_rx_q.size() > 0) ? mst_rx_q[0] : 8'hxx;
    checks++;
    if (got !== 8'h3C) begin
      errors++;
      $display("FAIL byte_miso: got %h exp 3c", got);
    end
    checks++;
    if (tx_ready_cnt !== 1) begin
      errors++;
      $display("FAIL byte_tx_ready: got %0d exp 1", tx_ready_cnt);
    end
    checks++;
    if (frame_done_cnt !== 1) begin
      errors++;
      $display("FAIL byte_frame_done: got %0d exp 1", frame_done_cnt);
    end
  endtask

  task automatic test_modes();
    logic [7:0] exp_rx[3];
    logic [7:0] exp_tx[3];
    logic [7:0] got;
    exp_rx = '{8'h01, 8'h80, 8'hFF};
    exp_tx = '{8'hC3, 8'h81, 8'h7E};
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0], 1'b1);
      clear_mon();
      slv_tx_q = '{8'hC3, 8'h81, 8'h7E};
      mst_tx_q = '{8'h01, 8'h80, 8'hFF};
      spi_frame(3, 0);
      checks++;
      if (rx_got_q.size() !== 3) begin
        errors++;
        $display("FAIL mode%0d_rx_count: got %0d exp 3", m, rx_got_q.size());
      end
      for (int k = 0; k < 3; k++) begin
        got = (rx_got_q.size() > k) ? rx_got_q[k] : 8'hxx;
        checks++;
        if (got !== exp_rx[k]) begin
          errors++;
          $display("FAIL mode%0d_rx_byte%0d: got %h exp %h", m, k, got, exp_rx[k]);
        end
        got = (mst_rx_q.size() > k) ? mst_rx_q[k] : 8'hxx;
        checks++;
        if (got !== exp_tx[k]) begin
          errors++;
          $display("FAIL mode%0d_miso_byte%0d: got %h exp %h", m, k, got, exp_tx[k]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    logic [7:0] got;
    set_mode(1'b0, 1'b0, 1'b0);
    clear_mon();
    slv_tx_q = '{8'hA1};
    mst_tx_q = '{8'h12, 8'h34};
    spi_frame(2, 0);
    checks++;
    if (first_ur_rx !== 0) begin
      errors++;
      $display("FAIL underrun_timing: got rx_count %0d at first underrun exp 0", first_ur_rx);
    end
    checks++;
    if (underrun_cnt !== 2) begin
      errors++;
      $display("FAIL underrun_count: got %0d exp 2", underrun_cnt);
    end
    got = (mst_rx_q.size() > 0) ? mst_rx_q[0] : 8'hxx;
    checks++;
    if (got !== 8'hA1) begin
      errors++;
      $display("FAIL underrun_miso0: got %h exp a1", got);
    end
    got = (mst_rx_q.size() > 1) ? mst_rx_q[1] : 8'hxx;
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL underrun_miso1: got %h exp 00", got);
    end
    got = (rx_got_q.size() > 1) ? rx_got_q[1] : 8'hxx;
    checks++;
    if (got !== 8'h34) begin
      errors++;
      $display("FAIL underrun_rx1: got %h exp 34", got);
    end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    set_mode(1'b0, 1'b0, 1'b0);
    clear_mon();
    slv_tx_q = '{8'hFF};
    mst_tx_q = '{8'hFF};
    spi_frame(1, 5);
    checks++;
    if (rx_got_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_rx_valid: got %0d pulses exp 0", rx_got_q.size());
    end
    checks++;
    if (frame_done_cnt !== 1) begin
      errors++;
      $display("FAIL abort_frame_done: got %0d exp 1", frame_done_cnt);
    end
    checks++;
    if (bad_trans !== 0 || spi_state !== 2'b00) begin
      errors++;
      $display("FAIL abort_state: got bad_trans %0d state %0d exp 0 0", bad_trans, spi_state);
    end
    clear_mon();
    slv_tx_q = '{8'hC5};
    mst_tx_q = '{8'h5A};
    spi_frame(1, 0);
    got = (rx_got_q.size() > 0) ? rx_got_q[0] : 8'hxx;
    checks++;
    if (got !== 8'h5A || rx_got_q.size() !== 1) begin
      errors++;
      $display("FAIL abort_next_rx: got %h (%0d bytes) exp 5a (1)", got, rx_got_q.size());
    end
    got = (mst_rx_q.size() > 0) ? mst_rx_q[0] : 8'hxx;
    checks++;
    if (got !== 8'hC5) begin
      errors++;
      $display("FAIL abort_next_miso: got %h exp c5", got);
    end
  endtask

  task automatic test_disable();
    clear_mon();
    en = 1'b0;
    ss = 1'b0;
    wait_clk(20);
    checks++;
    if (spi_state !== 2'b00 || miso_en !== 1'b0) begin
      errors++;
      $display("FAIL disable: got state %0d miso_en %b exp 0 0", spi_state, miso_en);
    end
    ss = 1'b1;
    wait_clk(6);
    en = 1'b1;
    checks++;
    if (frame_done_cnt !== 0) begin
      errors++;
      $display("FAIL disable_frame_done: got %0d exp 0", frame_done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    set_mode(1'b0, 1'b0, 1'b0);
    clear_mon();
    slv_tx_q = '{8'hFF};
    ss = 1'b0;
    mosi = 1'b1;
    wait_clk(2 * HALF);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
      wait_clk(HALF);
    end
    checks++;
    if (spi_state !== 2'b01 || miso !== 1'b1 || miso_en !== 1'b1) begin
      errors++;
      $display("FAIL midbyte_pre: got state %0d miso %b en %b exp 1 1 1", spi_state, miso, miso_en);
    end
    nreset = 1'b0;
    wait_clk(1);
    checks++;
    if ({miso, miso_en, rx_valid, tx_ready, tx_underrun, frame_done, spi_state, rx_data} !== 16'h0) begin
      errors++;
      $display("FAIL midbyte_reset: got %h exp 0",
               {miso, miso_en, rx_valid, tx_ready, tx_underrun, frame_done, spi_state, rx_data});
    end
    ss = 1'b1;
    mosi = 1'b0;
    slv_tx_q.delete();
    wait_clk(3);
    nreset = 1'b1;
    wait_clk(6);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tx[$];
    logic [7:0] got;
    set_mode(1'b0, 1'b0, 1'b0);
    clear_mon();
    mst_tx_q.delete();
    slv_tx_q.delete();
    for (int k = 0; k < 16; k++) begin
      mst_tx_q.push_back(8'($urandom_range(0, 255)));
      exp_tx.push_back(8'($urandom_range(0, 255)));
    end
    slv_tx_q = exp_tx;
    spi_frame(16, 0);
    checks++;
    if (rx_got_q.size() !== 16) begin
      errors++;
      $display("FAIL b2b_rx_count: got %0d exp 16", rx_got_q.size());
    end
    for (int k = 0; k < 16; k++) begin
      got = (rx_got_q.size() > k) ? rx_got_q[k] : 8'hxx;
      checks++;
      if (got !== mst_tx_q[k]) begin
        errors++;
        $display("FAIL b2b_rx%0d: got %h exp %h", k, got, mst_tx_q[k]);
      end
      got = (mst_rx_q.size() > k) ? mst_rx_q[k] : 8'hxx;
      checks++;
      if (got !== exp_tx[k]) begin
        errors++;
        $display("FAIL b2b_miso%0d: got %h exp %h", k, got, exp_tx[k]);
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    en = 1'b1;
    test_byte();
    test_modes();
    test_underrun();
    test_abort();
    test_disable();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
